// File: rtl/maze_walker.sv
// maze_walker: wall-follower maze solver with a left/right-hand rule selected
// at run start, grid-boundary awareness, a saturating step counter with
// timeout, and found/failed status.
// Optional feature: define MAZE_WALKER_PATH_EN to keep a visited-cell map on
// `path`. Without it, `path` reads as all zero and there is no path storage.
module maze_walker #(
    parameter int SIZE      = 9,
    parameter int N         = $clog2(SIZE),
    parameter int MAX_STEPS = 1023,
    parameter int SW        = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      hand,
    input  logic [SIZE-1:0][SIZE-1:0] maze,
    output logic [N-1:0]              x,
    output logic [N-1:0]              y,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic                      timeout,
    output logic [SW-1:0]             steps,
    output logic [SIZE-1:0][SIZE-1:0] path
);

    typedef enum logic [2:0] {
        IDLE, FIND_EXIT, FIND_ENTRY, VISIT, PICK, MOVE, DONE
    } state_t;

    // Headings: adding 1 turns right, subtracting 1 turns left.
    localparam logic [1:0] HN = 2'd0, HE = 2'd1, HS = 2'd2, HW = 2'd3;
    localparam logic [N-1:0]  LAST = N'(SIZE - 1);
    localparam logic [SW-1:0] MAXS = SW'(MAX_STEPS);

    state_t        state, state_n;
    logic [N-1:0]  x_n, y_n, ex, ex_n;
    logic [1:0]    hd, hd_n;
    logic          hand_q, hand_n;
    logic [SW-1:0] steps_n;
    logic          found_n, timeout_n;
    logic [3:0]    opn;
    logic [1:0]    c0, c1, c2, c3;

    // Open neighbours per heading; anything beyond the grid edge is a wall.
    always_comb begin
        opn[HN] = (y != '0)   && !maze[y - N'(1)][x];
        opn[HE] = (x != LAST) && !maze[y][x + N'(1)];
        opn[HS] = (y != LAST) && !maze[y + N'(1)][x];
        opn[HW] = (x != '0)   && !maze[y][x - N'(1)];
        c0 = hand_q ? hd - 2'd1 : hd + 2'd1;
        c1 = hd;
        c2 = hand_q ? hd + 2'd1 : hd - 2'd1;
        c3 = hd + 2'd2;
    end

    // Next-state, datapath updates and status outputs.
    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        ex_n      = ex;
        hd_n      = hd;
        hand_n    = hand_q;
        steps_n   = steps;
        found_n   = found;
        timeout_n = timeout;
        busy      = (state != IDLE) && (state != DONE);
        done      = (state == DONE);
        case (state)
            IDLE, DONE: if (start) begin
                state_n   = FIND_EXIT;
                x_n       = '0;
                y_n       = '0;
                ex_n      = '0;
                hd_n      = HS;
                hand_n    = hand;
                steps_n   = '0;
                found_n   = 1'b0;
                timeout_n = 1'b0;
            end
            FIND_EXIT: begin
                if (!maze[SIZE-1][ex]) state_n = FIND_ENTRY;
                else if (ex == LAST)   state_n = DONE;
                else                   ex_n = ex + N'(1);
            end
            FIND_ENTRY: begin
                if (!maze[0][x])     state_n = VISIT;
                else if (x == LAST)  state_n = DONE;
                else                 x_n = x + N'(1);
            end
            VISIT: begin
                if (x == ex && y == LAST) begin
                    found_n = 1'b1;
                    state_n = DONE;
                end else if (steps == MAXS) begin
                    timeout_n = 1'b1;
                    state_n   = DONE;
                end else begin
                    state_n = PICK;
                end
            end
            PICK: begin
                state_n = MOVE;
                if      (opn[c0]) hd_n = c0;
                else if (opn[c1]) hd_n = c1;
                else if (opn[c2]) hd_n = c2;
                else if (opn[c3]) hd_n = c3;
                else              state_n = DONE;
            end
            MOVE: begin
                case (hd)
                    HN:      y_n = y - N'(1);
                    HE:      x_n = x + N'(1);
                    HS:      y_n = y + N'(1);
                    default: x_n = x - N'(1);
                endcase
                steps_n = (steps == '1) ? steps : steps + SW'(1);
                state_n = VISIT;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            ex      <= '0;
            hd      <= HS;
            hand_q  <= 1'b0;
            steps   <= '0;
            found   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            x       <= x_n;
            y       <= y_n;
            ex      <= ex_n;
            hd      <= hd_n;
            hand_q  <= hand_n;
            steps   <= steps_n;
            found   <= found_n;
            timeout <= timeout_n;
        end
    end

`ifdef MAZE_WALKER_PATH_EN
    logic [SIZE-1:0][SIZE-1:0] path_q;
    logic path_clr, path_set;
    assign path_clr = ((state == IDLE) || (state == DONE)) && start;
    assign path_set = (state == VISIT);

    // Visited-cell map: cleared on each accepted start, marked on every visit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          path_q <= '0;
        else if (path_clr) path_q <= '0;
        else if (path_set) path_q[y][x] <= 1'b1;
    end
    assign path = path_q;
`else
    assign path = '0;
`endif

endmodule

// File: tb/tb_maze_walker.sv
// Directed bench for maze_walker: corridors, a branch maze (hand-rule
// difference), blocked exit row, timeout loop, left-edge entry, mid-run reset.
module tb_maze_walker;
    localparam int SIZE = 9, N = 4, SW = 10;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, hand = 1'b0, start2 = 1'b0;
    logic [SIZE-1:0][SIZE-1:0] maze, maze2, path, path2, exp_path;
    logic [N-1:0]  x, y, x2, y2;
    logic          busy, done, found, timeout, busy2, done2, found2, timeout2;
    logic [SW-1:0] steps, steps2;
    int n_cmp = 0, n_bad = 0;

    maze_walker #(.SIZE(SIZE), .N(N), .MAX_STEPS(1023), .SW(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .hand(hand), .maze(maze),
        .x(x), .y(y), .busy(busy), .done(done), .found(found),
        .timeout(timeout), .steps(steps), .path(path));

    maze_walker #(.SIZE(SIZE), .N(N), .MAX_STEPS(20), .SW(SW)) dut_to (
        .clk(clk), .rst(rst), .start(start2), .hand(hand), .maze(maze2),
        .x(x2), .y(y2), .busy(busy2), .done(done2), .found(found2),
        .timeout(timeout2), .steps(steps2), .path(path2));

    always #5 clk = ~clk;

    // Open column `col` for every row.
    task automatic corridor(input int col);
        maze = '1;
        for (int r = 0; r < SIZE; r++) maze[r][col] = 1'b0;
    endtask

    task automatic corridor_path(input int col);
        exp_path = '0;
`ifdef MAZE_WALKER_PATH_EN
        for (int r = 0; r < SIZE; r++) exp_path[r][col] = 1'b1;
`endif
    endtask

    // Start one run on dut; hand is flipped after acceptance to prove latching.
    task automatic run(input logic h, output int cyc, output logic bsy, output int xmax);
        @(negedge clk); hand = h; start = 1'b1;
        @(negedge clk); start = 1'b0; hand = ~h;
        bsy = busy; cyc = 0; xmax = int'(x);
        while (done !== 1'b1 && cyc < 500) begin
            @(negedge clk); cyc++;
            if (int'(x) > xmax) xmax = int'(x);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; #3;
        n_cmp++; if ({x, y, busy, done, found, timeout, steps} !== '0) begin n_bad++;
            $display("FAIL reset_outs: got x=%0d y=%0d b=%b d=%b f=%b t=%b s=%0d want all 0", x, y, busy, done, found, timeout, steps); end
        n_cmp++; if (path !== '0) begin n_bad++; $display("FAIL reset_path: got %h want 0", path); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_corridor();
        int cyc, xm; logic bsy;
        corridor(4); corridor_path(4);
        foreach (hand_v[i]) begin
            run(hand_v[i], cyc, bsy, xm);
            n_cmp++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL corr_busy h=%0d: got %b want 1", i, bsy); end
            n_cmp++; if (cyc != 35) begin n_bad++; $display("FAIL corr_cycles h=%0d: got %0d want 35", i, cyc); end
            n_cmp++; if ({found, timeout, busy} !== 3'b100) begin n_bad++; $display("FAIL corr_status h=%0d: got f/t/b=%b%b%b want 100", i, found, timeout, busy); end
            n_cmp++; if (steps !== 10'd8) begin n_bad++; $display("FAIL corr_steps h=%0d: got %0d want 8", i, steps); end
            n_cmp++; if (x !== 4'd4 || y !== 4'd8) begin n_bad++; $display("FAIL corr_pos h=%0d: got (%0d,%0d) want (4,8)", i, x, y); end
            n_cmp++; if (path !== exp_path) begin n_bad++; $display("FAIL corr_path h=%0d: got %h want %h", i, path, exp_path); end
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || x !== 4'd4) begin n_bad++; $display("FAIL done_held: got done=%b x=%0d want 1,4", done, x); end
    endtask
    logic hand_v [2] = '{1'b0, 1'b1};

    // Corridor in column 4 plus an east pocket at row 2; only the left hand explores it.
    task automatic test_branch();
        int cyc, xm; logic bsy;
        corridor(4); maze[2][5] = 1'b0; maze[2][6] = 1'b0;
        corridor_path(4);
        run(1'b0, cyc, bsy, xm);
        n_cmp++; if (cyc != 35 || steps !== 10'd8 || found !== 1'b1) begin n_bad++;
            $display("FAIL branch_right: got cyc=%0d steps=%0d found=%b want 35,8,1", cyc, steps, found); end
        n_cmp++; if (path !== exp_path) begin n_bad++; $display("FAIL branch_right_path: got %h want %h", path, exp_path); end
`ifdef MAZE_WALKER_PATH_EN
        exp_path[2][5] = 1'b1; exp_path[2][6] = 1'b1;
`endif
        run(1'b1, cyc, bsy, xm);
        n_cmp++; if (cyc != 47 || steps !== 10'd12 || found !== 1'b1) begin n_bad++;
            $display("FAIL branch_left: got cyc=%0d steps=%0d found=%b want 47,12,1", cyc, steps, found); end
        n_cmp++; if (x !== 4'd4 || y !== 4'd8) begin n_bad++; $display("FAIL branch_left_pos: got (%0d,%0d) want (4,8)", x, y); end
        n_cmp++; if (path !== exp_path) begin n_bad++; $display("FAIL branch_left_path: got %h want %h", path, exp_path); end
    endtask

    task automatic test_no_exit();
        int cyc, xm; logic bsy;
        corridor(4); maze[8] = '1;
        run(1'b0, cyc, bsy, xm);
        n_cmp++; if (cyc != 9) begin n_bad++; $display("FAIL noexit_cycles: got %0d want 9", cyc); end
        n_cmp++; if ({found, timeout} !== 2'b00 || steps !== '0) begin n_bad++;
            $display("FAIL noexit_status: got f=%b t=%b steps=%0d want 0,0,0", found, timeout, steps); end
    endtask

    task automatic test_left_edge();
        int cyc, xm; logic bsy;
        corridor(0); corridor_path(0);
        run(1'b0, cyc, bsy, xm);
        n_cmp++; if (cyc != 27 || found !== 1'b1 || steps !== 10'd8) begin n_bad++;
            $display("FAIL edge_run: got cyc=%0d found=%b steps=%0d want 27,1,8", cyc, found, steps); end
        n_cmp++; if (xm != 0 || y !== 4'd8) begin n_bad++; $display("FAIL edge_nowrap: got xmax=%0d y=%0d want 0,8", xm, y); end
        n_cmp++; if (path !== exp_path) begin n_bad++; $display("FAIL edge_path: got %h want %h", path, exp_path); end
    endtask

    // Dead-end stub at (1,0)-(1,1); exit at (5,8) is unreachable, walker bounces.
    task automatic test_timeout();
        int cyc = 0;
        maze2 = '1; maze2[0][1] = 1'b0; maze2[1][1] = 1'b0; maze2[8][5] = 1'b0;
        exp_path = '0;
`ifdef MAZE_WALKER_PATH_EN
        exp_path[0][1] = 1'b1; exp_path[1][1] = 1'b1;
`endif
        @(negedge clk); hand = 1'b0; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        while (done2 !== 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
        n_cmp++; if (cyc != 69) begin n_bad++; $display("FAIL to_cycles: got %0d want 69", cyc); end
        n_cmp++; if ({timeout2, found2} !== 2'b10) begin n_bad++; $display("FAIL to_status: got t=%b f=%b want 1,0", timeout2, found2); end
        n_cmp++; if (steps2 !== 10'd20 || x2 !== 4'd1 || y2 !== 4'd0) begin n_bad++;
            $display("FAIL to_steps_pos: got steps=%0d (%0d,%0d) want 20 (1,0)", steps2, x2, y2); end
        n_cmp++; if (path2 !== exp_path) begin n_bad++; $display("FAIL to_path: got %h want %h", path2, exp_path); end
    endtask

    task automatic test_start_ignored();
        int cyc = 0;
        corridor(4);
        @(negedge clk); hand = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (done !== 1'b1 && cyc < 500) begin
            @(negedge clk); cyc++;
            start = (cyc == 3 || cyc == 20);
        end
        start = 1'b0;
        n_cmp++; if (cyc != 35 || steps !== 10'd8 || found !== 1'b1) begin n_bad++;
            $display("FAIL ignore_start: got cyc=%0d steps=%0d found=%b want 35,8,1", cyc, steps, found); end
    endtask

    task automatic test_reset_mid_run();
        int cyc, xm; logic bsy;
        corridor(4); corridor_path(4);
        @(negedge clk); hand = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (18) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || steps !== 10'd2 || y !== 4'd2) begin n_bad++;
            $display("FAIL mid_pre: got busy=%b steps=%0d y=%0d want 1,2,2", busy, steps, y); end
        #2 rst = 1'b0; #1;
        n_cmp++; if ({x, y, busy, done, found, timeout, steps} !== '0 || path !== '0) begin n_bad++;
            $display("FAIL mid_reset: got x=%0d y=%0d b=%b d=%b f=%b t=%b s=%0d want all 0", x, y, busy, done, found, timeout, steps); end
        @(negedge clk); rst = 1'b1;
        run(1'b0, cyc, bsy, xm);
        n_cmp++; if (cyc != 35 || steps !== 10'd8 || found !== 1'b1 || path !== exp_path) begin n_bad++;
            $display("FAIL mid_rerun: got cyc=%0d steps=%0d found=%b want 35,8,1", cyc, steps, found); end
    endtask

    initial begin
        maze = '1; maze2 = '1; exp_path = '0;
        test_reset();
        test_corridor();
        test_branch();
        test_no_exit();
        test_left_edge();
        test_timeout();
        test_start_ignored();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/maze_walker.md
# maze_walker

Parametrised wall-follower maze solver; successor to the fixed 9×9 right-hand walker. Adds a run handshake, runtime-selectable left/right-hand rule, explicit grid-boundary handling, a saturating step counter with timeout, and found/failed status. Sits beside the maze source and drives the path display and scoring logic.

## Interface
- `SIZE`, 9: maze side length in cells, 3..64.
- `N`, `$clog2(SIZE)`: coordinate width.
- `MAX_STEPS`, 1023: moves before timeout; must fit in `SW`.
- `SW`, 10: step counter width.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted at 0).
- `start`  in  1: run request, sampled in IDLE and DONE only.
- `hand`  in  1: 0 = right-hand rule, 1 = left-hand rule; latched on accepted `start`.
- `maze`  in  SIZE×SIZE: `maze[y][x]`, 1 = wall, row 0 = top; must stay stable while `busy`.
- `x`, `y`  out  N: current position.
- `busy`  out  1: run in progress.
- `done`  out  1: run finished; held until next accepted `start`.
- `found`  out  1: exit reached; valid when `done`.
- `timeout`  out  1: run ended at `MAX_STEPS`; valid when `done`.
- `steps`  out  SW: moves taken in this run.
- `path`  out  SIZE×SIZE: visited-cell map, `path[y][x]`.

## Operation
- States: IDLE, FIND_EXIT, FIND_ENTRY, VISIT, PICK, MOVE, DONE.
- IDLE/DONE + `start`=1: clear `path`, `steps`, `done`, `found`, `timeout`; `x`=0, `y`=0, exit column `ex`=0; latch `hand`; heading = S; go to FIND_EXIT.
- FIND_EXIT: if `maze[SIZE-1][ex]`=0 go to FIND_ENTRY, else `ex`++. If `ex`=SIZE-1 and still wall: DONE, `found`=0.
- FIND_ENTRY: same scan of row 0 using `x`; first open cell → VISIT; none → DONE, `found`=0.
- VISIT: set `path[y][x]`=1. If (`x`,`y`)=(`ex`,SIZE-1): DONE, `found`=1. Else if `steps`=MAX_STEPS: DONE, `timeout`=1. Else PICK.
- PICK: candidate order relative to heading h: right-hand = right(h), h, left(h), back(h); left-hand = left(h), h, right(h), back(h). Headings N(y-1), E(x+1), S(y+1), W(x-1); right(S)=W, right(W)=N, right(N)=E, right(E)=S. First open candidate becomes heading. Out-of-grid neighbour counts as wall. No open candidate: DONE, `found`=0.
- MOVE: step one cell along heading, `steps`++ (saturates at all-ones), → VISIT.
- `start` during FIND_*/VISIT/PICK/MOVE is ignored.
- `hand`/`maze` changes mid-run: `hand` ignored (latched); `maze` change is undefined.

## Timing
- Reset values: state IDLE, `x`=`y`=0, `busy`=`done`=`found`=`timeout`=0, `steps`=0, `path` all 0.
- `busy`=1 from cycle after accepted `start` until cycle DONE is entered; `done` rises same cycle `busy` falls.
- Scan: one column per cycle; exit scan takes ex+1 cycles, entry scan x0+1 cycles.
- Each move costs 3 cycles (VISIT, PICK, MOVE); final VISIT 1 cycle.
- Total cycles start→`done` = (ex+1)+(x0+1)+3·steps+1.
- `rst` low mid-run: immediate return to reset values; no partial status retained.

## Configuration
- `MAZE_WALKER_PATH_EN` defined: `path` register and VISIT write implemented as above.
- Undefined: `path` tied to all-zero, no path storage; all other behaviour and timing unchanged.

## Test plan
- 9×9 straight corridor, column 4 open rows 0..8, `hand`=0, `start` pulse → `found`=1, `steps`=8, `x`=4, `y`=8, `done` at cycle 5+5+24+1=35; `path` column 4 set.
- Same maze with `hand`=1 → identical result; serpentine maze → right- and left-hand `steps` differ, both `found`=1.
- Bottom row all walls → `done` after 9 cycles, `found`=0, `steps`=0.
- Closed loop with `MAX_STEPS`=20 → `done`, `timeout`=1, `found`=0, `steps`=20.
- Entry at x=0 on left edge, open only downward → no out-of-grid move, x never wraps to SIZE-1.
- `rst`=0 mid-MOVE → all outputs at reset values next cycle; `start` after release reruns cleanly; `start` pulses during run ignored.
